// File: rtl/lfsr_checker_32bits.sv
// ---------------------------------------------------------------------------
// lfsr_checker_32bits
//
// Receive-side checker for a 32-bit LFSR pattern generator using
// x^32+x^30+x^11+x^5+1 in shift-right form. It seeds from the incoming
// stream, declares lock after LOCK_MATCHES consecutive correct predictions,
// then flywheels its own prediction and counts mismatched words. After
// LOSS_MISMATCHES consecutive mismatches it drops back to hunting.
//
// Handshake: a word is consumed on a rising clk edge where in_valid=1;
// there is no back-pressure. With in_valid=0 all state holds and
// err_pulse is 0 (clr_err still acts).
//
// Ports
//   clk         in   clock, rising edge
//   rst         in   asynchronous active-high reset
//   in_valid    in   qualifies in_data this cycle
//   in_data     in   [31:0] received word
//   clr_err     in   synchronous clear of err_count
//   locked      out  high while in LOCKED
//   err_pulse   out  one-cycle pulse per mismatched word counted in LOCKED
//   err_count   out  [15:0] saturating error count
//   expected    out  [31:0] prediction of the next valid word
//   o_dbg_state out  FSM state (0 = HUNT, 1 = LOCKED)
// ---------------------------------------------------------------------------
module lfsr_checker_32bits #(
  parameter int LOCK_MATCHES    = 4,
  parameter int LOSS_MISMATCHES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  input  logic        clr_err,
  output logic        locked,
  output logic        err_pulse,
  output logic [15:0] err_count,
  output logic [31:0] expected,
  output logic        o_dbg_state
);

  typedef enum logic {S_HUNT = 1'b0, S_LOCKED = 1'b1} state_t;

  localparam logic [3:0] LOCK_C = 4'(LOCK_MATCHES);
  localparam logic [3:0] LOSS_C = 4'(LOSS_MISMATCHES);

  function automatic logic [31:0] lfsr_next(input logic [31:0] w);
    return {w[0] ^ w[2] ^ w[21] ^ w[27], w[31:1]};
  endfunction

  state_t      r_state;
  logic        r_seeded;
  logic [3:0]  r_match_cnt;
  logic [3:0]  r_miss_cnt;
  logic [31:0] r_expected;
  logic        r_err_pulse;
  logic [15:0] r_err_count;

  state_t      w_state_nxt;
  logic        w_seeded_nxt;
  logic [3:0]  w_match_nxt;
  logic [3:0]  w_miss_nxt;
  logic [31:0] w_expected_nxt;
  logic        w_err;
  logic [15:0] w_count_nxt;

  logic        w_hit;
  logic        w_zero;
  logic [3:0]  w_match_inc;
  logic [3:0]  w_miss_inc;

  assign w_hit       = (in_data == r_expected);
  assign w_zero      = (in_data == 32'h0);
  assign w_match_inc = r_match_cnt + 4'd1;
  assign w_miss_inc  = r_miss_cnt + 4'd1;

  // State register plus datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_HUNT;
      r_seeded    <= 1'b0;
      r_match_cnt <= 4'd0;
      r_miss_cnt  <= 4'd0;
      r_expected  <= 32'h0;
      r_err_pulse <= 1'b0;
      r_err_count <= 16'h0;
    end else begin
      r_state     <= w_state_nxt;
      r_seeded    <= w_seeded_nxt;
      r_match_cnt <= w_match_nxt;
      r_miss_cnt  <= w_miss_nxt;
      r_expected  <= w_expected_nxt;
      r_err_pulse <= w_err;
      r_err_count <= w_count_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    if (in_valid) begin
      case (r_state)
        S_HUNT: begin
          if (!w_zero && r_seeded && w_hit && (w_match_inc == LOCK_C))
            w_state_nxt = S_LOCKED;
        end
        S_LOCKED: begin
          if (!w_hit && (w_miss_inc == LOSS_C))
            w_state_nxt = S_HUNT;
        end
        default: w_state_nxt = S_HUNT;
      endcase
    end
  end

  // Datapath / output next values
  always_comb begin
    w_seeded_nxt   = r_seeded;
    w_match_nxt    = r_match_cnt;
    w_miss_nxt     = r_miss_cnt;
    w_expected_nxt = r_expected;
    w_err          = 1'b0;
    if (in_valid) begin
      case (r_state)
        S_HUNT: begin
          if (w_zero) begin
            // Zero is the lockup word: it can never be a valid seed.
            w_seeded_nxt = 1'b0;
            w_match_nxt  = 4'd0;
          end else if (!r_seeded || !w_hit) begin
            w_expected_nxt = lfsr_next(in_data);
            w_seeded_nxt   = 1'b1;
            w_match_nxt    = 4'd0;
          end else begin
            w_expected_nxt = lfsr_next(in_data);
            if (w_match_inc == LOCK_C) begin
              w_match_nxt = 4'd0;
              w_miss_nxt  = 4'd0;
            end else begin
              w_match_nxt = w_match_inc;
            end
          end
        end
        S_LOCKED: begin
          // Flywheel: once locked the prediction never reseeds from data.
          w_expected_nxt = lfsr_next(r_expected);
          if (w_hit) begin
            w_miss_nxt = 4'd0;
          end else begin
            w_err = 1'b1;
            if (w_miss_inc == LOSS_C) begin
              w_seeded_nxt = 1'b0;
              w_miss_nxt   = 4'd0;
              w_match_nxt  = 4'd0;
            end else begin
              w_miss_nxt = w_miss_inc;
            end
          end
        end
        default: ;
      endcase
    end

    w_count_nxt = r_err_count;
    if (w_err && (r_err_count != 16'hFFFF))
      w_count_nxt = r_err_count + 16'd1;
    // A clear coincident with a counted error keeps that error.
    if (clr_err)
      w_count_nxt = w_err ? 16'd1 : 16'd0;
  end

  assign locked      = (r_state == S_LOCKED);
  assign err_pulse   = r_err_pulse;
  assign err_count   = r_err_count;
  assign expected    = r_expected;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_lfsr_checker_32bits.sv
// ---------------------------------------------------------------------------
// tb_lfsr_checker_32bits
//
// Directed bench. dut uses default parameters; dut_s (LOCK_MATCHES=1,
// LOSS_MISMATCHES=15) is used only to drive err_count into saturation
// within a short run while staying locked.
// Inputs are driven 1 ns after a rising edge and outputs are sampled 1 ns
// after the edge that consumes them.
// ---------------------------------------------------------------------------
module tb_lfsr_checker_32bits;

  logic        clk;
  logic        rst;
  logic        in_valid, clr_err;
  logic [31:0] in_data;
  logic        locked, err_pulse, dbg_state;
  logic [15:0] err_count;
  logic [31:0] expected;

  logic        s_valid, s_clr;
  logic [31:0] s_data;
  logic        s_locked, s_err_pulse, s_dbg_state;
  logic [15:0] s_err_count;
  logic [31:0] s_expected;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] w;   // next word the generator would send to dut
  logic [31:0] sw;  // same for dut_s

  lfsr_checker_32bits dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .clr_err(clr_err), .locked(locked), .err_pulse(err_pulse),
    .err_count(err_count), .expected(expected), .o_dbg_state(dbg_state)
  );

  lfsr_checker_32bits #(.LOCK_MATCHES(1), .LOSS_MISMATCHES(15)) dut_s (
    .clk(clk), .rst(rst), .in_valid(s_valid), .in_data(s_data),
    .clr_err(s_clr), .locked(s_locked), .err_pulse(s_err_pulse),
    .err_count(s_err_count), .expected(s_expected), .o_dbg_state(s_dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Generator model: shift right, feedback from taps 0,2,21,27
  function automatic logic [31:0] gen_next(input logic [31:0] x);
    return {x[0] ^ x[2] ^ x[21] ^ x[27], x[31:1]};
  endfunction

  // Driver tasks
  task automatic drive(input logic v, input logic [31:0] d, input logic c);
    in_valid = v; in_data = d; clr_err = c;
    @(posedge clk); #1;
    in_valid = 1'b0; clr_err = 1'b0;
  endtask

  task automatic drive_s(input logic v, input logic [31:0] d);
    s_valid = v; s_data = d;
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (locked !== 1'b0) begin n_err++; $display("FAIL reset_locked got=%0b exp=0", locked); end
    n_vec++; if (err_pulse !== 1'b0) begin n_err++; $display("FAIL reset_err_pulse got=%0b exp=0", err_pulse); end
    n_vec++; if (err_count !== 16'h0) begin n_err++; $display("FAIL reset_err_count got=%h exp=0000", err_count); end
    n_vec++; if (expected !== 32'h0) begin n_err++; $display("FAIL reset_expected got=%h exp=00000000", expected); end
    n_vec++; if (dbg_state !== 1'b0) begin n_err++; $display("FAIL reset_state got=%0b exp=0", dbg_state); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_seed();
    drive(1'b1, 32'hDEADFACE, 1'b0);
    n_vec++; if (expected !== 32'hEF56FD67) begin n_err++; $display("FAIL seed_expected got=%h exp=EF56FD67", expected); end
    n_vec++; if (locked !== 1'b0) begin n_err++; $display("FAIL seed_locked got=%0b exp=0", locked); end
    n_vec++; if (err_count !== 16'h0) begin n_err++; $display("FAIL seed_err_count got=%h exp=0000", err_count); end
    w = 32'hEF56FD67;
  endtask

  // Four successors after the seed: lock rises on the fourth.
  task automatic test_lock();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, w, 1'b0);
      w = gen_next(w);
      n_vec++; if (err_pulse !== 1'b0) begin n_err++; $display("FAIL lock_err_pulse[%0d] got=%0b exp=0", i, err_pulse); end
      n_vec++; if (locked !== (i == 3)) begin n_err++; $display("FAIL lock_locked[%0d] got=%0b exp=%0b", i, locked, (i == 3)); end
      n_vec++; if (expected !== w) begin n_err++; $display("FAIL lock_expected[%0d] got=%h exp=%h", i, expected, w); end
      if (i == 0) begin
        n_vec++; if (expected !== 32'hF7AB7EB3) begin n_err++; $display("FAIL lock_hand_next got=%h exp=F7AB7EB3", expected); end
      end
    end
  endtask

  task automatic test_single_error();
    drive(1'b1, w ^ 32'h1, 1'b0);
    w = gen_next(w);
    n_vec++; if (err_pulse !== 1'b1) begin n_err++; $display("FAIL single_pulse got=%0b exp=1", err_pulse); end
    n_vec++; if (err_count !== 16'd1) begin n_err++; $display("FAIL single_count got=%0d exp=1", err_count); end
    n_vec++; if (locked !== 1'b1) begin n_err++; $display("FAIL single_locked got=%0b exp=1", locked); end
    n_vec++; if (expected !== w) begin n_err++; $display("FAIL single_flywheel got=%h exp=%h", expected, w); end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, w, 1'b0);
      w = gen_next(w);
      n_vec++; if (err_pulse !== 1'b0) begin n_err++; $display("FAIL single_after_pulse[%0d] got=%0b exp=0", i, err_pulse); end
      n_vec++; if (err_count !== 16'd1) begin n_err++; $display("FAIL single_after_count[%0d] got=%0d exp=1", i, err_count); end
      n_vec++; if (locked !== 1'b1) begin n_err++; $display("FAIL single_after_locked[%0d] got=%0b exp=1", i, locked); end
    end
  endtask

  task automatic test_gaps();
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, $urandom_range(0, 32'hFFFF), 1'b0);
      n_vec++; if (locked !== 1'b1 || err_pulse !== 1'b0 || expected !== w)
        begin n_err++; $display("FAIL gap_hold[%0d] got=%0b/%0b/%h exp=1/0/%h", i, locked, err_pulse, expected, w); end
    end
    drive(1'b1, w, 1'b0);
    w = gen_next(w);
    n_vec++; if (locked !== 1'b1 || err_pulse !== 1'b0 || err_count !== 16'd1)
      begin n_err++; $display("FAIL gap_resume got=%0b/%0b/%0d exp=1/0/1", locked, err_pulse, err_count); end
  endtask

  task automatic test_clr_coincident();
    drive(1'b1, ~w, 1'b1);
    w = gen_next(w);
    n_vec++; if (err_count !== 16'd1) begin n_err++; $display("FAIL clr_coincident_count got=%0d exp=1", err_count); end
    n_vec++; if (err_pulse !== 1'b1) begin n_err++; $display("FAIL clr_coincident_pulse got=%0b exp=1", err_pulse); end
    drive(1'b1, w, 1'b1);
    w = gen_next(w);
    n_vec++; if (err_count !== 16'd0) begin n_err++; $display("FAIL clr_plain_count got=%0d exp=0", err_count); end
    n_vec++; if (locked !== 1'b1 || expected !== w) begin n_err++; $display("FAIL clr_plain_state got=%0b/%h exp=1/%h", locked, expected, w); end
  endtask

  task automatic test_loss_relock();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, w ^ 32'h5, 1'b0);
      w = gen_next(w);
      n_vec++; if (err_pulse !== 1'b1) begin n_err++; $display("FAIL loss_pulse[%0d] got=%0b exp=1", i, err_pulse); end
      n_vec++; if (err_count !== 16'(i + 1)) begin n_err++; $display("FAIL loss_count[%0d] got=%0d exp=%0d", i, err_count, i + 1); end
      n_vec++; if (locked !== (i != 2)) begin n_err++; $display("FAIL loss_locked[%0d] got=%0b exp=%0b", i, locked, (i != 2)); end
    end
    w = 32'h12345678;
    drive(1'b1, w, 1'b0);
    w = gen_next(w);
    n_vec++; if (expected !== w || locked !== 1'b0) begin n_err++; $display("FAIL relock_seed got=%h/%0b exp=%h/0", expected, locked, w); end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, w, 1'b0);
      w = gen_next(w);
      n_vec++; if (locked !== (i == 3) || err_pulse !== 1'b0)
        begin n_err++; $display("FAIL relock[%0d] got=%0b/%0b exp=%0b/0", i, locked, err_pulse, (i == 3)); end
    end
    n_vec++; if (err_count !== 16'd3) begin n_err++; $display("FAIL relock_count got=%0d exp=3", err_count); end
  endtask

  task automatic test_zero_hunt();
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h0, 1'b0);
      n_vec++; if (locked !== 1'b0 || err_pulse !== 1'b0 || expected !== 32'h0 || err_count !== 16'h0)
        begin n_err++; $display("FAIL zero_hunt[%0d] got=%0b/%0b/%h/%0d exp=0/0/0/0", i, locked, err_pulse, expected, err_count); end
    end
    // A zero between a seed and its successor must unseed the checker.
    w = 32'hA5A5_0001;
    drive(1'b1, w, 1'b0);
    w = gen_next(w);
    drive(1'b1, 32'h0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, w, 1'b0);
      w = gen_next(w);
      n_vec++; if (locked !== (i == 4) || err_pulse !== 1'b0)
        begin n_err++; $display("FAIL zero_unseed[%0d] got=%0b/%0b exp=%0b/0", i, locked, err_pulse, (i == 4)); end
    end
  endtask

  task automatic test_reset_mid_lock();
    drive(1'b1, ~w, 1'b0);
    w = gen_next(w);
    n_vec++; if (err_count !== 16'd1 || locked !== 1'b1) begin n_err++; $display("FAIL mid_pre got=%0d/%0b exp=1/1", err_count, locked); end
    #3 rst = 1'b1;
    #1;
    n_vec++; if (locked !== 1'b0 || err_count !== 16'h0 || expected !== 32'h0 || err_pulse !== 1'b0)
      begin n_err++; $display("FAIL mid_async got=%0b/%0d/%h/%0b exp=0/0/0/0", locked, err_count, expected, err_pulse); end
    @(posedge clk); #1; rst = 1'b0;
    // The previous stream's next word now must only seed.
    drive(1'b1, w, 1'b0);
    w = gen_next(w);
    n_vec++; if (locked !== 1'b0 || expected !== w) begin n_err++; $display("FAIL mid_seed got=%0b/%h exp=0/%h", locked, expected, w); end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, w, 1'b0);
      w = gen_next(w);
    end
    n_vec++; if (locked !== 1'b1 || err_count !== 16'h0) begin n_err++; $display("FAIL mid_relock got=%0b/%0d exp=1/0", locked, err_count); end
  endtask

  // dut_s: 4681 blocks of 14 errors + 1 match = 65534 errors, then more.
  task automatic test_saturation();
    sw = 32'hCAFEBABE;
    drive_s(1'b1, sw); sw = gen_next(sw);
    drive_s(1'b1, sw); sw = gen_next(sw);
    n_vec++; if (s_locked !== 1'b1) begin n_err++; $display("FAIL sat_lock got=%0b exp=1", s_locked); end
    for (int b = 0; b < 4681; b++) begin
      for (int i = 0; i < 14; i++) begin
        drive_s(1'b1, ~sw); sw = gen_next(sw);
      end
      drive_s(1'b1, sw); sw = gen_next(sw);
    end
    n_vec++; if (s_err_count !== 16'hFFFE || s_locked !== 1'b1)
      begin n_err++; $display("FAIL sat_fffe got=%h/%0b exp=fffe/1", s_err_count, s_locked); end
    drive_s(1'b1, ~sw); sw = gen_next(sw);
    n_vec++; if (s_err_count !== 16'hFFFF) begin n_err++; $display("FAIL sat_ffff got=%h exp=ffff", s_err_count); end
    for (int i = 0; i < 2; i++) begin
      drive_s(1'b1, ~sw); sw = gen_next(sw);
      n_vec++; if (s_err_count !== 16'hFFFF || s_err_pulse !== 1'b1)
        begin n_err++; $display("FAIL sat_hold[%0d] got=%h/%0b exp=ffff/1", i, s_err_count, s_err_pulse); end
    end
  endtask

  // Sequencer and final report
  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_data = 32'h0; clr_err = 1'b0;
    s_valid = 1'b0; s_data = 32'h0; s_clr = 1'b0;
    w = 32'h0; sw = 32'h0;
    test_reset();
    test_seed();
    test_lock();
    test_single_error();
    test_gaps();
    test_clr_coincident();
    test_loss_relock();
    test_zero_hunt();
    test_reset_mid_lock();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
